l2_dmem_xbar: RTL and testbench

- Parametrised banked L2 data memory with NUM_PORTS independent valid/ready request ports and NUM_BANKS single-port banks.
- Each port issues reads or writes. Per-bank round-robin arbitration resolves bank conflicts, so ports stall instead of corrupting data.
- Read data returns on a fixed-latency response channel per port.
- Sits between core/DMA/NoC masters and the bank SRAMs; successor of the fixed 4-port, 8-bank L2 dmem.

---
 rtl/l2_dmem_pkg.sv | 35 +++
 rtl/l2_dmem_rr_arb.sv | 47 ++++
 rtl/l2_dmem_xbar.sv | 161 ++++++++++++++++
 tb/tb_l2_dmem_xbar.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/l2_dmem_pkg.sv
// l2_dmem_pkg: shared constants and address-decode helpers for the banked
// L2 data memory crossbar.
//   - L2_* localparams : default geometry of the crossbar
//   - bank_of / row_of : split a word address into bank index and row index,
//                        selecting high-bit or low-bit (word interleave) banking
package l2_dmem_pkg;

    localparam int unsigned L2_NUM_PORTS  = 4;
    localparam int unsigned L2_NUM_BANKS  = 8;
    localparam int unsigned L2_BANK_DEPTH = 1024;
    localparam int unsigned L2_DATA_W     = 256;

    // Bank index: low address bits when interleaved, otherwise the top BANK_W bits.
    function automatic logic [31:0] bank_of(input logic [31:0] addr,
                                            input int unsigned addr_w,
                                            input int unsigned bank_w,
                                            input int unsigned interleave);
        logic [31:0] mask;
        mask = (32'd1 << bank_w) - 32'd1;
        if (interleave != 0)
            return addr & mask;
        return (addr >> (addr_w - bank_w)) & mask;
    endfunction

    // Row index: the address bits left over after the bank index is removed.
    function automatic logic [31:0] row_of(input logic [31:0] addr,
                                           input int unsigned addr_w,
                                           input int unsigned bank_w,
                                           input int unsigned interleave);
        if (interleave != 0)
            return addr >> bank_w;
        return addr & ((32'd1 << (addr_w - bank_w)) - 32'd1);
    endfunction

endpackage

// File: rtl/l2_dmem_rr_arb.sv
// l2_dmem_rr_arb: round-robin arbiter for one bank.
//   clk, rst_n : clock, asynchronous active-low reset (pointer -> 0)
//   req_i      : NUM_PORTS request vector
//   gnt_o      : one-hot grant; lowest requesting index at or after the
//                pointer wins, pointer moves to winner+1 only on a grant
module l2_dmem_rr_arb #(
    parameter int unsigned NUM_PORTS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_PORTS-1:0] req_i,
    output logic [NUM_PORTS-1:0] gnt_o
);

    localparam int unsigned PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             found;

    // Two passes: indices from the pointer upward, then the wrapped-around
    // indices below the pointer. The first hit in that order wins.
    always_comb begin
        gnt_o = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        for (int unsigned j = 0; j < NUM_PORTS; j++) begin
            if (!found && req_i[j] && (j >= 32'(ptr_q))) begin
                gnt_o[j] = 1'b1;
                found    = 1'b1;
                ptr_d    = (j == NUM_PORTS - 1) ? '0 : PTR_W'(j + 1);
            end
        end
        for (int unsigned j = 0; j < NUM_PORTS; j++) begin
            if (!found && req_i[j] && (j < 32'(ptr_q))) begin
                gnt_o[j] = 1'b1;
                found    = 1'b1;
                ptr_d    = (j == NUM_PORTS - 1) ? '0 : PTR_W'(j + 1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/l2_dmem_xbar.sv
// l2_dmem_xbar: banked L2 data memory with NUM_PORTS valid/ready request
// ports and NUM_BANKS single-port banks, per-bank round-robin arbitration and
// a fixed one-cycle read response per port.
//   clk, rst_n            : clock, asynchronous active-low reset
//   req_valid/req_ready   : per-port handshake (ready is combinational)
//   req_we                : 1 = write, 0 = read
//   req_addr/req_wdata    : packed per-port word address / write data
//   rsp_valid/rsp_rdata   : read response one cycle after acceptance;
//                           rsp_rdata holds its last value when not valid
//   stall_cnt             : per-port saturating 32-bit stall counters, present
//                           only when L2_DMEM_XBAR_STALL_CNT_EN is defined
module l2_dmem_xbar
    import l2_dmem_pkg::*;
#(
    parameter int unsigned NUM_PORTS  = L2_NUM_PORTS,
    parameter int unsigned NUM_BANKS  = L2_NUM_BANKS,
    parameter int unsigned BANK_DEPTH = L2_BANK_DEPTH,
    parameter int unsigned DATA_W     = L2_DATA_W,
    parameter int unsigned INTERLEAVE = 0,
    parameter int unsigned BANK_W     = $clog2(NUM_BANKS),
    parameter int unsigned ADDR_W     = BANK_W + $clog2(BANK_DEPTH)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_PORTS-1:0]        req_valid,
    output logic [NUM_PORTS-1:0]        req_ready,
    input  logic [NUM_PORTS-1:0]        req_we,
    input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
    input  logic [NUM_PORTS*DATA_W-1:0] req_wdata,
    output logic [NUM_PORTS-1:0]        rsp_valid,
`ifdef L2_DMEM_XBAR_STALL_CNT_EN
    output logic [NUM_PORTS*DATA_W-1:0] rsp_rdata,
    output logic [NUM_PORTS*32-1:0]     stall_cnt
`else
    output logic [NUM_PORTS*DATA_W-1:0] rsp_rdata
`endif
);

    localparam int unsigned ROW_W = ADDR_W - BANK_W;

    logic [BANK_W-1:0]    port_bank [NUM_PORTS];
    logic [ROW_W-1:0]     port_row  [NUM_PORTS];
    logic [NUM_PORTS-1:0] bank_req  [NUM_BANKS];
    logic [NUM_PORTS-1:0] bank_gnt  [NUM_BANKS];
    logic                 bank_en   [NUM_BANKS];
    logic                 bank_we   [NUM_BANKS];
    logic [ROW_W-1:0]     bank_row  [NUM_BANKS];
    logic [DATA_W-1:0]    bank_wdata[NUM_BANKS];
    logic [DATA_W-1:0]    bank_rd   [NUM_BANKS];

    logic [NUM_PORTS-1:0] rsp_pend_q, rsp_pend_d;
    logic [BANK_W-1:0]    rsp_bank_q[NUM_PORTS];
    logic [DATA_W-1:0]    rsp_hold_q[NUM_PORTS];

    // Address decode and per-bank request vectors.
    always_comb begin
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            port_bank[p] = BANK_W'(bank_of(32'(req_addr[p*ADDR_W +: ADDR_W]), ADDR_W, BANK_W, INTERLEAVE));
            port_row[p]  = ROW_W'(row_of(32'(req_addr[p*ADDR_W +: ADDR_W]), ADDR_W, BANK_W, INTERLEAVE));
        end
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            for (int unsigned p = 0; p < NUM_PORTS; p++)
                bank_req[b][p] = req_valid[p] && (port_bank[p] == BANK_W'(b));
        end
    end

    // A port requests exactly one bank, so ORing all bank grants gives its ready.
    always_comb begin
        req_ready = '0;
        for (int unsigned b = 0; b < NUM_BANKS; b++)
            req_ready = req_ready | bank_gnt[b];
    end

    // One-hot grant steers the winning port's command onto each bank.
    always_comb begin
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            bank_en[b]    = 1'b0;
            bank_we[b]    = 1'b0;
            bank_row[b]   = '0;
            bank_wdata[b] = '0;
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                if (bank_gnt[b][p]) begin
                    bank_en[b]    = 1'b1;
                    bank_we[b]    = req_we[p];
                    bank_row[b]   = port_row[p];
                    bank_wdata[b] = req_wdata[p*DATA_W +: DATA_W];
                end
            end
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [DATA_W-1:0] mem [BANK_DEPTH];
        logic [DATA_W-1:0] rd_q;

        l2_dmem_rr_arb #(.NUM_PORTS(NUM_PORTS)) u_arb (
            .clk   (clk),
            .rst_n (rst_n),
            .req_i (bank_req[b]),
            .gnt_o (bank_gnt[b])
        );

        always_ff @(posedge clk) begin
            if (bank_en[b]) begin
                if (bank_we[b]) mem[bank_row[b]] <= bank_wdata[b];
                else            rd_q <= mem[bank_row[b]];
            end
        end

        assign bank_rd[b] = rd_q;
    end

    assign rsp_pend_d = req_valid & req_ready & ~req_we;

    // The bank read register can be reused by another port next cycle, so each
    // port keeps its own copy to hold rsp_rdata stable between responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_pend_q <= '0;
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                rsp_bank_q[p] <= '0;
                rsp_hold_q[p] <= '0;
            end
        end else begin
            rsp_pend_q <= rsp_pend_d;
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                rsp_bank_q[p] <= port_bank[p];
                if (rsp_pend_q[p]) rsp_hold_q[p] <= bank_rd[rsp_bank_q[p]];
            end
        end
    end

    always_comb begin
        rsp_valid = rsp_pend_q;
        for (int unsigned p = 0; p < NUM_PORTS; p++)
            rsp_rdata[p*DATA_W +: DATA_W] = rsp_pend_q[p] ? bank_rd[rsp_bank_q[p]] : rsp_hold_q[p];
    end

`ifdef L2_DMEM_XBAR_STALL_CNT_EN
    logic [31:0] stall_q[NUM_PORTS];
    logic [31:0] stall_d[NUM_PORTS];

    always_comb begin
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            stall_d[p] = stall_q[p];
            if (req_valid[p] && !req_ready[p] && (stall_q[p] != '1))
                stall_d[p] = stall_q[p] + 32'd1;
            stall_cnt[p*32 +: 32] = stall_q[p];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned p = 0; p < NUM_PORTS; p++) stall_q[p] <= '0;
        end else begin
            for (int unsigned p = 0; p < NUM_PORTS; p++) stall_q[p] <= stall_d[p];
        end
    end
`endif

endmodule

// File: tb/tb_l2_dmem_xbar.sv
// tb_l2_dmem_xbar: directed-vector bench for l2_dmem_xbar. One instance uses
// high-bit banking, a second uses word interleave. Inputs change on the
// falling edge; req_ready is sampled 1 ns later, responses on the next
// falling edge.
module tb_l2_dmem_xbar;

    localparam int unsigned NP = 4;
    localparam int unsigned NB = 8;
    localparam int unsigned BD = 64;
    localparam int unsigned DW = 64;
    localparam int unsigned AW = 9;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NP-1:0]    req_valid, req_ready, req_we, rsp_valid;
    logic [NP*AW-1:0] req_addr;
    logic [NP*DW-1:0] req_wdata, rsp_rdata;

    logic [NP-1:0]    il_valid, il_ready, il_we, il_rsp_valid;
    logic [NP*AW-1:0] il_addr;
    logic [NP*DW-1:0] il_wdata, il_rdata;

`ifdef L2_DMEM_XBAR_STALL_CNT_EN
    logic [NP*32-1:0] stall_cnt, il_stall_cnt;
    logic [31:0]      s0 [NP];
`endif

    int n_vec;
    int n_err;

    always #5 clk = ~clk;

    l2_dmem_xbar #(.NUM_PORTS(NP), .NUM_BANKS(NB), .BANK_DEPTH(BD), .DATA_W(DW), .INTERLEAVE(0)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
`ifdef L2_DMEM_XBAR_STALL_CNT_EN
        .stall_cnt(stall_cnt),
`endif
        .rsp_rdata(rsp_rdata)
    );

    l2_dmem_xbar #(.NUM_PORTS(NP), .NUM_BANKS(NB), .BANK_DEPTH(BD), .DATA_W(DW), .INTERLEAVE(1)) u_dut_il (
        .clk(clk), .rst_n(rst_n),
        .req_valid(il_valid), .req_ready(il_ready), .req_we(il_we),
        .req_addr(il_addr), .req_wdata(il_wdata),
        .rsp_valid(il_rsp_valid),
`ifdef L2_DMEM_XBAR_STALL_CNT_EN
        .stall_cnt(il_stall_cnt),
`endif
        .rsp_rdata(il_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rd(input int p);
        return rsp_rdata[p*DW +: DW];
    endfunction

    function automatic logic [AW-1:0] addr0(input int b, input int r);
        return {3'(b), 6'(r)};
    endfunction

    function automatic logic [DW-1:0] dpat(input int r);
        return 64'hD0D0_0000_0000_0000 | 64'(r);
    endfunction

    task automatic idle();
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    endtask

    task automatic set_req(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[p] = 1'b1;
        req_we[p]    = we;
        req_addr[p*AW +: AW]  = a;
        req_wdata[p*DW +: DW] = d;
    endtask

    // All four ports read bank 0 (port p -> row p+1) and hold valid until granted.
    task automatic conflict(input int first);
        logic [NP-1:0] pend;
        int            e;
        pend = '1;
        for (int c = 0; c < 4; c++) begin
            e = (first + c) % 4;
            for (int p = 0; p < 4; p++)
                if (pend[p]) set_req(p, 1'b0, addr0(0, p + 1), '0);
            #1 chk("rr_ready", 64'(req_ready), 64'(4'b0001 << e));
            @(negedge clk);
            idle();
            pend[e] = 1'b0;
            chk("rr_rsp_valid", 64'(rsp_valid), 64'(4'b0001 << e));
            chk("rr_rdata", rd(e), dpat(e + 1));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_vec = 0; n_err = 0;
        rst_n = 1'b0;
        idle();
        il_valid = '0; il_we = '0; il_addr = '0; il_wdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_rdata", 64'(|rsp_rdata), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", 64'(req_ready), 64'd0);
        chk("idle_rsp_valid", 64'(rsp_valid), 64'd0);

        // Write port0, then read port1 same address.
        set_req(0, 1'b1, 9'h005, {8{8'hA5}});
        #1 chk("wr_ready", 64'(req_ready), 64'b0001);
        @(negedge clk); idle();
        chk("wr_no_rsp", 64'(rsp_valid), 64'd0);
        set_req(1, 1'b0, 9'h005, '0);
        #1 chk("rd_ready", 64'(req_ready), 64'b0010);
        @(negedge clk); idle();
        chk("rd_rsp_valid", 64'(rsp_valid), 64'b0010);
        chk("rd_rdata", rd(1), {8{8'hA5}});
        @(negedge clk);
        chk("rd_pulse_end", 64'(rsp_valid), 64'd0);
        chk("rd_hold", rd(1), {8{8'hA5}});

        // Reset while a read is in flight.
        set_req(0, 1'b0, 9'h005, '0);
        #1 chk("mid_ready", 64'(req_ready), 64'b0001);
        @(posedge clk); #1 rst_n = 1'b0; idle();
        @(negedge clk);
        chk("mid_rst_valid", 64'(rsp_valid), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_valid", 64'(rsp_valid), 64'd0);
        chk("post_rst_rdata", 64'(|rsp_rdata), 64'd0);

        // Preload bank 0 rows 1-4 through port 3 (pointer returns to 0).
        for (int r = 1; r <= 4; r++) begin
            set_req(3, 1'b1, addr0(0, r), dpat(r));
            #1 chk("pre_ready", 64'(req_ready), 64'b1000);
            @(negedge clk); idle();
        end

        conflict(0);
        // Single grant to port 0 leaves the bank-0 pointer at 1.
        set_req(0, 1'b0, addr0(0, 1), '0);
        #1 chk("ptr1_ready", 64'(req_ready), 64'b0001);
        @(negedge clk); idle();
        chk("ptr1_rdata", rd(0), dpat(1));
        conflict(1);

        // Four ports, four different banks: all granted together.
        for (int p = 0; p < 4; p++) set_req(p, 1'b1, addr0(p, 7), dpat(16 + p));
        #1 chk("par_wr_ready", 64'(req_ready), 64'hF);
        @(negedge clk); idle();
        for (int p = 0; p < 4; p++) set_req(p, 1'b0, addr0(p, 7), '0);
        #1 chk("par_rd_ready", 64'(req_ready), 64'hF);
        @(negedge clk); idle();
        chk("par_rsp_valid", 64'(rsp_valid), 64'hF);
        for (int p = 0; p < 4; p++) chk("par_rdata", rd(p), dpat(16 + p));

`ifdef L2_DMEM_XBAR_STALL_CNT_EN
        // Three-way conflict on bank 5: port1 waits 1 cycle, port2 waits 2.
        for (int p = 0; p < NP; p++) s0[p] = stall_cnt[p*32 +: 32];
        for (int c = 0; c < 3; c++) begin
            for (int p = c; p < 3; p++) set_req(p, 1'b0, addr0(5, p + 1), '0);
            #1 chk("stall_ready", 64'(req_ready), 64'(4'b0001 << c));
            @(negedge clk); idle();
        end
        for (int p = 0; p < 3; p++)
            chk("stall_delta", 64'(stall_cnt[p*32 +: 32] - s0[p]), 64'(p));
`endif

        // Word-interleaved instance: write 0..15 then stream reads on port 2.
        for (int a = 0; a < 16; a++) begin
            il_valid = 4'b0100; il_we = 4'b0100;
            il_addr[2*AW +: AW] = AW'(a); il_wdata[2*DW +: DW] = DW'(a);
            #1 chk("il_wr_ready", 64'(il_ready), 64'b0100);
            @(negedge clk);
        end
        il_we = '0;
        for (int a = 0; a < 16; a++) begin
            il_valid = 4'b0100;
            il_addr[2*AW +: AW] = AW'(a);
            #1 chk("il_rd_ready", 64'(il_ready), 64'b0100);
            @(negedge clk);
            chk("il_rsp_valid", 64'(il_rsp_valid), 64'b0100);
            chk("il_rdata", il_rdata[2*DW +: DW], 64'(a));
        end
        // Addresses 0..3 land in banks 0..3 only when interleaved.
        il_valid = 4'hF;
        for (int p = 0; p < 4; p++) il_addr[p*AW +: AW] = AW'(p);
        #1 chk("il_par_ready", 64'(il_ready), 64'hF);
        @(negedge clk);
        il_valid = '0;
        chk("il_par_valid", 64'(il_rsp_valid), 64'hF);
        chk("il_par_rdata3", il_rdata[3*DW +: DW], 64'd3);
        @(negedge clk);
        chk("il_idle_valid", 64'(il_rsp_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
